// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: scan classes,
// width helpers and parameter range checking.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_class_t;

  // Width of a binary key code for an n_rows x n_cols matrix.
  function automatic int code_width(input int n_rows, input int n_cols);
    return (n_rows * n_cols > 1) ? $clog2(n_rows * n_cols) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // True when every parameter lies in its legal range.
  function automatic bit params_ok(input int n_rows, input int n_cols,
                                   input int scan_div, input int debounce_scans,
                                   input int repeat_delay, input int repeat_rate);
    return (n_rows >= 1) && (n_cols >= 1) && (n_rows * n_cols >= 2) &&
           (scan_div >= 4) && (debounce_scans >= 1) &&
           (repeat_delay >= 0) && (repeat_rate >= 1);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for asynchronous level inputs, with a
// configurable reset level so idle lines do not look active after reset.
module sync_2ff #(
  parameter int WIDTH     = 1,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= {WIDTH{RESET_VAL}};
      q    <= {WIDTH{RESET_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives columns one at a time, snapshots the
// synchronized rows, debounces over whole scans and reports a single
// accepted key with press/release/auto-repeat events and a ghost flag.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_RATE    = 2,
  localparam int CODE_W        = code_width(N_ROWS, N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] rows,
  output logic [N_COLS-1:0] cols,
  output logic              key_valid,
  output logic              key_release,
  output logic [CODE_W-1:0] key_code,
  output logic              key_down,
  output logic              multi_key
);

  localparam int N_KEYS = N_ROWS * N_COLS;
  localparam int COL_W  = count_width(N_COLS - 1);
  localparam int SLOT_W = count_width(SCAN_DIV - 1);
  localparam int DEB_W  = count_width(DEBOUNCE_SCANS);
  localparam int REP_W  = count_width(max_int(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(N_COLS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX     = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [REP_W-1:0]  REP_DELAY_C = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0]  REP_RATE_C  = REP_W'(REPEAT_RATE);
  localparam bit                REPEAT_EN   = (REPEAT_DELAY > 0);

  if (!params_ok(N_ROWS, N_COLS, SCAN_DIV, DEBOUNCE_SCANS, REPEAT_DELAY, REPEAT_RATE)) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [N_ROWS-1:0] rows_sync;

  sync_2ff #(
    .WIDTH     (N_ROWS),
    .RESET_VAL (1'b1)
  ) u_rows_sync (
    .clk (clk),
    .rst (rst),
    .d   (rows),
    .q   (rows_sync)
  );

  // Scan sequencer state
  logic              running;
  logic [COL_W-1:0]  col_idx, next_col;
  logic [SLOT_W-1:0] slot_cnt, next_slot;
  logic              slot_last, scan_end;

  // Snapshot and classification
  logic [N_KEYS-1:0] snap, scan_bits;
  logic [1:0]        hits;
  scan_class_t       scan_class;
  logic [CODE_W-1:0] scan_code, raw_code;

  // Debouncer / stable state
  scan_class_t       cand_class, cand_class_n, stable_class, stable_class_n;
  logic [CODE_W-1:0] cand_code, cand_code_n, key_code_n;
  logic [DEB_W-1:0]  stab_cnt, stab_cnt_n;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_n;
  logic              rep_first, rep_first_n;
  logic              key_valid_n, key_release_n, key_down_n, multi_key_n;
  logic              changed;

  assign slot_last = running && (slot_cnt == SLOT_LAST);
  assign scan_end  = slot_last && (col_idx == COL_LAST);

  // Next column/slot position; holds at column 0 until the scan starts.
  always_comb begin
    next_slot = slot_cnt;
    next_col  = col_idx;
    if (running) begin
      if (slot_last) begin
        next_slot = '0;
        next_col  = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
      end else begin
        next_slot = slot_cnt + 1'b1;
      end
    end
  end

  // Column drive register: idle during reset, then one low column at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      col_idx  <= '0;
      slot_cnt <= '0;
      cols     <= '1;
    end else begin
      running  <= 1'b1;
      col_idx  <= next_col;
      slot_cnt <= next_slot;
      cols     <= ~(N_COLS'(1) << next_col);
    end
  end

  // Full-matrix view with the column being sampled now merged in.
  always_comb begin
    scan_bits = snap;
    if (slot_last) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          if (col_idx == COL_W'(c)) scan_bits[r*N_COLS + c] = ~rows_sync[r];
        end
      end
    end
  end

  // Snapshot register updated on the last cycle of every column slot.
  always_ff @(posedge clk) begin
    if (rst) snap <= '0;
    else if (slot_last) snap <= scan_bits;
  end

  // Classify the completed scan as no key, one key (with code) or several.
  always_comb begin
    hits     = 2'd0;
    raw_code = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (scan_bits[i]) begin
        raw_code = CODE_W'(i);
        if (hits != 2'd2) hits = hits + 2'd1;
      end
    end
    scan_class = (hits == 2'd0) ? SCAN_NONE : (hits == 2'd1) ? SCAN_SINGLE : SCAN_MULTI;
    scan_code  = (hits == 2'd1) ? raw_code : '0;
  end

  // Debounce, stable-state transitions, event generation and auto-repeat.
  always_comb begin
    cand_class_n   = cand_class;
    cand_code_n    = cand_code;
    stab_cnt_n     = stab_cnt;
    stable_class_n = stable_class;
    key_code_n     = key_code;
    key_down_n     = key_down;
    multi_key_n    = multi_key;
    rep_cnt_n      = rep_cnt;
    rep_first_n    = rep_first;
    key_valid_n    = 1'b0;
    key_release_n  = 1'b0;
    changed        = 1'b0;
    if (scan_end) begin
      if (scan_class == cand_class && scan_code == cand_code) begin
        if (stab_cnt != DEB_MAX) stab_cnt_n = stab_cnt + 1'b1;
      end else begin
        cand_class_n = scan_class;
        cand_code_n  = scan_code;
        stab_cnt_n   = DEB_W'(1);
      end
      changed = (stab_cnt_n == DEB_MAX) &&
                ((cand_class_n != stable_class) ||
                 (cand_class_n == SCAN_SINGLE && cand_code_n != key_code));
      if (changed) begin
        stable_class_n = cand_class_n;
        rep_cnt_n      = '0;
        rep_first_n    = 1'b1;
        key_release_n  = key_down;
        unique case (cand_class_n)
          SCAN_SINGLE: begin
            key_valid_n = 1'b1;
            key_code_n  = cand_code_n;
            key_down_n  = 1'b1;
            multi_key_n = 1'b0;
          end
          SCAN_MULTI: begin
            key_down_n  = 1'b0;
            multi_key_n = 1'b1;
          end
          default: begin
            key_down_n  = 1'b0;
            multi_key_n = 1'b0;
          end
        endcase
      end else if (REPEAT_EN && stable_class == SCAN_SINGLE) begin
        rep_cnt_n = rep_cnt + 1'b1;
        if (rep_cnt_n == (rep_first ? REP_DELAY_C : REP_RATE_C)) begin
          key_valid_n = 1'b1;
          rep_cnt_n   = '0;
          rep_first_n = 1'b0;
        end
      end
    end
  end

  // Debouncer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_class   <= SCAN_NONE;
      cand_code    <= '0;
      stab_cnt     <= '0;
      stable_class <= SCAN_NONE;
      key_code     <= '0;
      key_down     <= 1'b0;
      multi_key    <= 1'b0;
      key_valid    <= 1'b0;
      key_release  <= 1'b0;
      rep_cnt      <= '0;
      rep_first    <= 1'b1;
    end else begin
      cand_class   <= cand_class_n;
      cand_code    <= cand_code_n;
      stab_cnt     <= stab_cnt_n;
      stable_class <= stable_class_n;
      key_code     <= key_code_n;
      key_down     <= key_down_n;
      multi_key    <= multi_key_n;
      key_valid    <= key_valid_n;
      key_release  <= key_release_n;
      rep_cnt      <= rep_cnt_n;
      rep_first    <= rep_first_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a default instance checked through a
// table of key patterns plus an event scoreboard, and an auto-repeat
// instance exercised with hand-written timing sequences.
module tb_keypad_scanner;

  localparam int SCAN = 16;

  typedef struct packed {
    logic       valid;
    logic       rel;
    logic [3:0] code;
    logic       down;
    logic       multi;
  } ev_t;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    bit          has_ev;
    bit          ev_valid;
    bit          ev_rel;
    logic [3:0]  code;
    bit          down;
    bit          multi;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys0, keys1;
  logic [3:0]  rows0, rows1, cols0, cols1, kc0, kc1;
  logic        kv0, kr0, kd0, mk0, kv1, kr1, kd1, mk1;

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  // Keypad model: a row reads low when a pressed key sits on a driven column.
  function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (keys[i*4 + j] && !cols[j]) r[i] = 1'b0;
    return r;
  endfunction

  assign rows0 = keypad_rows(keys0, cols0);
  assign rows1 = keypad_rows(keys1, cols1);

  keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(0), .REPEAT_RATE(2)
  ) dut0 (
    .clk(clk), .rst(rst), .rows(rows0), .cols(cols0),
    .key_valid(kv0), .key_release(kr0), .key_code(kc0),
    .key_down(kd0), .multi_key(mk0)
  );

  keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut1 (
    .clk(clk), .rst(rst), .rows(rows1), .cols(cols1),
    .key_valid(kv1), .key_release(kr1), .key_code(kc1),
    .key_down(kd1), .multi_key(mk1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int scans);
    @(negedge clk);
    keys0 = keys;
    repeat (scans * SCAN) @(negedge clk);
  endtask

  // Event monitor for dut0: every pulse must match the next expected event.
  always @(posedge clk) begin
    ev_t act;
    ev_t exp_ev;
    #1;
    act = {kv0, kr0, kc0, kd0, mk0};
    if (kv0 || kr0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected event: got %0h, expected no event", act);
      end else begin
        exp_ev = exp_q.pop_front();
        checkOutput("event", act, exp_ev);
      end
    end
  end

  initial begin
    vec_t vecs[10];
    int   offs[$];
    int   exp_off[3];
    int   n_acc;
    int   n_re;

    vecs[0] = '{16'h0000, 3, 0, 0, 0, 4'd0,  0, 0};
    vecs[1] = '{16'h0200, 6, 1, 1, 0, 4'd9,  1, 0};
    vecs[2] = '{16'h0000, 5, 1, 0, 1, 4'd9,  0, 0};
    vecs[3] = '{16'h0008, 5, 1, 1, 0, 4'd3,  1, 0};
    vecs[4] = '{16'h1000, 5, 1, 1, 1, 4'd12, 1, 0};
    vecs[5] = '{16'h0021, 5, 1, 0, 1, 4'd12, 0, 1};
    vecs[6] = '{16'h0000, 5, 0, 0, 0, 4'd12, 0, 0};
    vecs[7] = '{16'h0021, 5, 0, 0, 0, 4'd12, 0, 1};
    vecs[8] = '{16'h0001, 5, 1, 1, 0, 4'd0,  1, 0};
    vecs[9] = '{16'h0000, 5, 1, 0, 1, 4'd0,  0, 0};
    exp_off = '{64, 96, 128};

    rst   = 1'b1;
    keys0 = '0;
    keys1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset cols0", cols0, 4'hF);
    checkOutput("reset cols1", cols1, 4'hF);
    checkOutput("reset outputs0", {kv0, kr0, kc0, kd0, mk0}, 8'h00);
    checkOutput("reset outputs1", {kv1, kr1, kc1, kd1, mk1}, 8'h00);

    rst = 1'b0;
    @(negedge clk);
    checkOutput("first column", cols0, 4'b1110);
    repeat (4) @(negedge clk);
    checkOutput("second column", cols0, 4'b1101);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].has_ev)
        exp_q.push_back({vecs[i].ev_valid, vecs[i].ev_rel, vecs[i].code, vecs[i].down, vecs[i].multi});
      applyStimulus(vecs[i].keys, vecs[i].scans);
      checkOutput($sformatf("vec%0d key_down", i), kd0, vecs[i].down);
      checkOutput($sformatf("vec%0d multi_key", i), mk0, vecs[i].multi);
      checkOutput($sformatf("vec%0d key_code", i), kc0, vecs[i].code);
      checkOutput($sformatf("vec%0d pending events", i), exp_q.size(), 0);
    end

    // Contact bouncing faster than the debounce window must never be accepted.
    for (int t = 0; t < 8; t++) begin
      keys0 = (t % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (20) @(negedge clk);
      checkOutput("bounce key_down", kd0, 0);
    end
    keys0 = '0;
    repeat (3 * SCAN) @(negedge clk);
    checkOutput("bounce key_down final", kd0, 0);
    checkOutput("bounce pending events", exp_q.size(), 0);

    // Auto-repeat on dut1: accept, then pulses 4, 6 and 8 scans later.
    n_acc = 0;
    keys1 = 16'h8000;
    for (int n = 1; n <= 5 * SCAN + 3; n++) begin
      @(negedge clk);
      if (kv1) begin
        n_acc = n;
        break;
      end
    end
    checkOutput("repeat accept within bound", (n_acc != 0), 1);
    checkOutput("repeat accept code", kc1, 4'd15);
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (kv1) begin
        offs.push_back(k);
        checkOutput("repeat code", kc1, 4'd15);
      end
    end
    checkOutput("repeat pulse count", offs.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < offs.size()) checkOutput($sformatf("repeat offset %0d", i), offs[i], exp_off[i]);

    // Reset while the key is still held, then re-debounce from scratch.
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midhold reset outputs", {kv1, kr1, kc1, kd1, mk1}, 8'h00);
    checkOutput("midhold reset cols", cols1, 4'hF);
    @(negedge clk);
    rst  = 1'b0;
    n_re = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (kv1) begin
        n_re = n;
        break;
      end
    end
    checkOutput("reaccept latency", n_re, 49);
    checkOutput("reaccept code", kc1, 4'd15);
    checkOutput("reaccept key_down", kd1, 1);

    keys1 = '0;
    repeat (SCAN) @(negedge clk);
    checkOutput("final pending events", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
